// File: rtl/pop_count_seq_pkg.sv
// Shared constants, state encoding and helpers for the
// sequential population-count path.
package pop_count_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    function automatic int nslice(input int w);
        return w / SLICE_W;
    endfunction

endpackage

// File: rtl/pop_count_seq_compress.sv
// 8-to-4 compressor: number of ones in one byte,
// built as a small balanced adder tree.
module compress_8_4 (
    input  logic [7:0] x,
    output logic [3:0] y
);

    logic [1:0] w_s0;
    logic [1:0] w_s1;
    logic [1:0] w_s2;
    logic [1:0] w_s3;
    logic [2:0] w_t0;
    logic [2:0] w_t1;

    assign w_s0 = {1'b0, x[0]} + {1'b0, x[1]};
    assign w_s1 = {1'b0, x[2]} + {1'b0, x[3]};
    assign w_s2 = {1'b0, x[4]} + {1'b0, x[5]};
    assign w_s3 = {1'b0, x[6]} + {1'b0, x[7]};

    assign w_t0 = {1'b0, w_s0} + {1'b0, w_s1};
    assign w_t1 = {1'b0, w_s2} + {1'b0, w_s3};

    assign y = {1'b0, w_t0} + {1'b0, w_t1};

endmodule

// File: rtl/pop_count_seq.sv
// Sequential popcount: one compressor reused over byte slices
// of a captured sample, partial counts accumulated per cycle.
module pop_count_seq
    import pop_count_pkg::*;
#(
    parameter int SAMPLE_W = 32,
    parameter int CNT_W    = $clog2(SAMPLE_W + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_sample,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    out_count,
    output logic                busy
);

    localparam int NSLICE = nslice(SAMPLE_W);
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((SAMPLE_W % SLICE_W) != 0 || SAMPLE_W < SLICE_W) begin : g_bad_width
        $error("pop_count_seq: SAMPLE_W must be a multiple of 8, >= 8");
    end

    state_e              r_state;
    state_e              w_next;
    logic [SAMPLE_W-1:0] r_shift;
    logic [CNT_W-1:0]    r_acc;
    logic [IDX_W-1:0]    r_idx;
    logic [3:0]          w_y;
    logic                w_accept;
    logic                w_last;

    compress_8_4 u_cmp (
        .x (r_shift[SLICE_W-1:0]),
        .y (w_y)
    );

    assign in_ready  = (r_state == S_IDLE)
                     | ((r_state == S_DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_state == S_RUN)
                     & (r_idx == IDX_W'(NSLICE - 1));
    assign out_valid = (r_state == S_DONE);
    assign out_count = r_acc;
    assign busy      = (r_state == S_RUN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: DONE may chain straight into RUN on a handshake.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = in_valid ? S_RUN : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: load on accept, otherwise consume one slice per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_shift <= in_sample;
            r_acc   <= '0;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_shift <= r_shift >> SLICE_W;
            r_acc   <= r_acc + CNT_W'(w_y);
            r_idx   <= r_idx + IDX_W'(1);
        end
    end

endmodule
